// File: rtl/lc3b_mem_stage.sv
// lc3b_mem_stage -- MEM stage of the LC-3b pipeline.
//
// Performs every data-memory access for the instruction held in EX/MEM:
// word/byte loads and stores, two-access indirect ops (LDI/STI) and the
// TRAP vector fetch. Requests go to the data cache combinationally and are
// held until dmem_resp. While an access is outstanding mem_stall freezes all
// upstream pipeline registers, so the inputs (and the request) stay stable.
//
// Ports:
//   clk, reset            pipeline clock, synchronous active-high reset
//   in_valid, mem_op      EX/MEM holds a live instruction / memory op code
//   addr_in, sr_in        effective address / store data
//   alu_in, pc_in, dest_in  passthrough values for MEM/WB
//   dmem_*                cache request/response handshake
//   mem_stall             hold EX/MEM and all earlier stages
//   wb_valid, wb_data, wb_dest, wb_pc   result into MEM/WB
module lc3b_mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [2:0]  mem_op,
    input  logic [15:0] addr_in,
    input  logic [15:0] sr_in,
    input  logic [15:0] alu_in,
    input  logic [15:0] pc_in,
    input  logic [2:0]  dest_in,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [1:0]  dmem_byte_enable,
    output logic [15:0] dmem_address,
    output logic [15:0] dmem_wdata,
    input  logic [15:0] dmem_rdata,
    input  logic        dmem_resp,
    output logic        mem_stall,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [2:0]  wb_dest,
    output logic [15:0] wb_pc
);

    localparam logic [2:0] OP_NONE = 3'b000;
    localparam logic [2:0] OP_LDR  = 3'b001;
    localparam logic [2:0] OP_LDB  = 3'b010;
    localparam logic [2:0] OP_STR  = 3'b011;
    localparam logic [2:0] OP_STB  = 3'b100;
    localparam logic [2:0] OP_LDI  = 3'b101;
    localparam logic [2:0] OP_STI  = 3'b110;
    localparam logic [2:0] OP_TRAP = 3'b111;

    typedef enum logic {FIRST = 1'b0, SECOND = 1'b1} state_t;

    state_t      state, state_next;
    logic [15:0] ptr;
    logic        live, indirect, completing, load_ptr;
    logic [1:0]  byte_be;
    logic [7:0]  byte_sel;

    // Reset masks the request in the same cycle so the cache never sees a
    // strobe while it is itself being reset.
    assign live     = in_valid && (mem_op != OP_NONE) && !reset;
    assign indirect = (mem_op == OP_LDI) || (mem_op == OP_STI);
    assign byte_be  = addr_in[0] ? 2'b10 : 2'b01;
    assign byte_sel = addr_in[0] ? dmem_rdata[15:8] : dmem_rdata[7:0];

    assign wb_dest = dest_in;
    assign wb_pc   = pc_in;

    // State register (plus the indirection pointer)
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= FIRST;
            ptr   <= '0;
        end else begin
            state <= state_next;
            if (load_ptr)
                ptr <= dmem_rdata;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        load_ptr   = 1'b0;
        case (state)
            FIRST: begin
                if (live && indirect && dmem_resp) begin
                    state_next = SECOND;
                    load_ptr   = 1'b1;
                end
            end
            SECOND: begin
                // Losing the instruction here is a protocol violation; fall
                // back to FIRST rather than hold a stale second access.
                if (!live || dmem_resp)
                    state_next = FIRST;
            end
            default: state_next = FIRST;
        endcase
    end

    // Output logic
    always_comb begin
        dmem_read        = 1'b0;
        dmem_write       = 1'b0;
        dmem_byte_enable = 2'b00;
        dmem_address     = '0;
        dmem_wdata       = '0;
        completing       = 1'b0;
        wb_data          = alu_in;

        if (live) begin
            if (state == SECOND) begin
                // Second half of LDI/STI: word access at the fetched pointer.
                dmem_address     = {ptr[15:1], 1'b0};
                dmem_byte_enable = 2'b11;
                completing       = dmem_resp;
                if (mem_op == OP_STI) begin
                    dmem_write = 1'b1;
                    dmem_wdata = sr_in;
                end else begin
                    dmem_read = 1'b1;
                    wb_data   = dmem_rdata;
                end
            end else begin
                case (mem_op)
                    OP_LDR, OP_TRAP: begin
                        dmem_read        = 1'b1;
                        dmem_address     = {addr_in[15:1], 1'b0};
                        dmem_byte_enable = 2'b11;
                        completing       = dmem_resp;
                        wb_data          = dmem_rdata;
                    end
                    OP_LDI, OP_STI: begin
                        // Pointer fetch: never completes the instruction.
                        dmem_read        = 1'b1;
                        dmem_address     = {addr_in[15:1], 1'b0};
                        dmem_byte_enable = 2'b11;
                    end
                    OP_LDB: begin
                        dmem_read        = 1'b1;
                        dmem_address     = addr_in;
                        dmem_byte_enable = byte_be;
                        completing       = dmem_resp;
                        wb_data          = {{8{byte_sel[7]}}, byte_sel};
                    end
                    OP_STR: begin
                        dmem_write       = 1'b1;
                        dmem_address     = {addr_in[15:1], 1'b0};
                        dmem_byte_enable = 2'b11;
                        dmem_wdata       = sr_in;
                        completing       = dmem_resp;
                    end
                    OP_STB: begin
                        // Byte replicated on both lanes; the enable picks one.
                        dmem_write       = 1'b1;
                        dmem_address     = addr_in;
                        dmem_byte_enable = byte_be;
                        dmem_wdata       = {sr_in[7:0], sr_in[7:0]};
                        completing       = dmem_resp;
                    end
                    default: ;
                endcase
            end
        end

        mem_stall = live && !completing;
        wb_valid  = completing || (in_valid && (mem_op == OP_NONE) && !reset);
    end

endmodule

// File: tb/tb_lc3b_mem_stage.sv
module tb_lc3b_mem_stage;

    localparam logic [2:0] NONE = 3'd0, LDR = 3'd1, LDB = 3'd2, STR = 3'd3,
                           STB = 3'd4, LDI = 3'd5, STI = 3'd6, TRAP = 3'd7;

    logic        clk = 1'b0;
    logic        reset, in_valid;
    logic [2:0]  mem_op, dest_in;
    logic [15:0] addr_in, sr_in, alu_in, pc_in;
    logic        dmem_read, dmem_write;
    logic [1:0]  dmem_byte_enable;
    logic [15:0] dmem_address, dmem_wdata, dmem_rdata;
    logic        dmem_resp;
    logic        mem_stall, wb_valid;
    logic [15:0] wb_data, wb_pc;
    logic [2:0]  wb_dest;

    lc3b_mem_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .mem_op(mem_op),
        .addr_in(addr_in), .sr_in(sr_in), .alu_in(alu_in), .pc_in(pc_in),
        .dest_in(dest_in), .dmem_read(dmem_read), .dmem_write(dmem_write),
        .dmem_byte_enable(dmem_byte_enable), .dmem_address(dmem_address),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_data(wb_data),
        .wb_dest(wb_dest), .wb_pc(wb_pc)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [1:0]  be;
        logic [15:0] wdata;
    } acc_t;

    int n_tests = 0, n_fail = 0;
    logic [15:0] mem [0:32767];   // word-indexed cache backing store

    // Observations from the last run_op
    acc_t        got_acc[$];
    int          got_stalls, got_wbv, got_unstable, got_both;
    bit          got_timeout;
    logic [15:0] got_wbd, got_pc, cur_pc;
    logic [2:0]  got_dest, cur_dest;

    function automatic acc_t mk(input logic wr, input logic [15:0] a,
                                input logic [1:0] be, input logic [15:0] wd);
        acc_t r;
        r.wr = wr; r.addr = a; r.be = be; r.wdata = wd;
        return r;
    endfunction

    // Drives one instruction and acts as an N-wait cache until wb_valid.
    // Entered just after a rising edge; returns just after a rising edge.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, sr, alu,
                          input int nwait);
        acc_t cur, now;
        int   waitc = 0, cyc = 0;
        bit   done = 0;
        got_acc.delete();
        got_stalls = 0; got_wbv = 0; got_unstable = 0; got_both = 0;
        got_timeout = 0; got_wbd = 'x;
        cur_pc = 16'($urandom); cur_dest = 3'($urandom);
        in_valid = 1; mem_op = op; addr_in = a; sr_in = sr; alu_in = alu;
        pc_in = cur_pc; dest_in = cur_dest;
        while (!done) begin
            dmem_resp = 0; dmem_rdata = 16'($urandom);
            #1;
            if (dmem_read && dmem_write) got_both++;
            if (dmem_read || dmem_write) begin
                now = mk(dmem_write, dmem_address, dmem_byte_enable,
                         dmem_write ? dmem_wdata : 16'h0);
                if (waitc == 0) cur = now;
                else if (now !== cur) got_unstable++;
                if (waitc == nwait) begin
                    got_acc.push_back(now);
                    if (dmem_write) begin
                        if (dmem_byte_enable[1]) mem[dmem_address[15:1]][15:8] = dmem_wdata[15:8];
                        if (dmem_byte_enable[0]) mem[dmem_address[15:1]][7:0]  = dmem_wdata[7:0];
                    end else begin
                        dmem_rdata = mem[dmem_address[15:1]];
                    end
                    dmem_resp = 1;
                    waitc = 0;
                end else begin
                    waitc++;
                end
            end
            #1;
            if (mem_stall) got_stalls++;
            if (wb_valid) begin
                got_wbv++; got_wbd = wb_data; got_pc = wb_pc; got_dest = wb_dest;
                done = 1;
            end
            @(posedge clk); #1;
            cyc++;
            if (!done && cyc > 200) begin got_timeout = 1; done = 1; end
        end
        dmem_resp = 0;
    endtask

    task automatic test_reset;
        reset = 1; in_valid = 1; mem_op = LDR; addr_in = 16'h1234;
        pc_in = 16'hABCD; dest_in = 3'd5; dmem_resp = 0;
        mem[16'h091A] = 16'h5A5A;
        @(posedge clk); #1;
        n_tests++; if (dmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read got=%b exp=0", dmem_read); end
        n_tests++; if (dmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_write got=%b exp=0", dmem_write); end
        n_tests++; if (mem_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall got=%b exp=0", mem_stall); end
        n_tests++; if (wb_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wbv got=%b exp=0", wb_valid); end
        n_tests++; if (dmem_byte_enable !== 2'b00) begin n_fail++; $display("FAIL reset_be got=%b exp=00", dmem_byte_enable); end
        n_tests++; if (wb_pc !== 16'hABCD) begin n_fail++; $display("FAIL reset_pc got=%h exp=abcd", wb_pc); end
        reset = 0; #1;
        n_tests++; if (dmem_read !== 1'b1) begin n_fail++; $display("FAIL release_read got=%b exp=1", dmem_read); end
        n_tests++; if (dmem_address !== 16'h1234) begin n_fail++; $display("FAIL release_addr got=%h exp=1234", dmem_address); end
        run_op(LDR, 16'h1234, 16'h0, 16'h0, 0);
        n_tests++; if (got_wbd !== 16'h5A5A) begin n_fail++; $display("FAIL release_ldr_data got=%h exp=5a5a", got_wbd); end
        n_tests++; if (got_stalls !== 0) begin n_fail++; $display("FAIL release_ldr_stall got=%0d exp=0", got_stalls); end
    endtask

    task automatic test_ldb;
        mem[16'h1800] = 16'h80AB;
        run_op(LDB, 16'h3001, 16'h0, 16'h9999, 2);
        n_tests++; if (got_acc.size() !== 1) begin n_fail++; $display("FAIL ldb_nacc got=%0d exp=1", got_acc.size()); end
        else begin
            n_tests++; if (got_acc[0] !== mk(1'b0, 16'h3001, 2'b10, 16'h0)) begin n_fail++; $display("FAIL ldb_req got=%h exp=%h", got_acc[0], mk(1'b0, 16'h3001, 2'b10, 16'h0)); end
        end
        n_tests++; if (got_stalls !== 2) begin n_fail++; $display("FAIL ldb_stall got=%0d exp=2", got_stalls); end
        n_tests++; if (got_wbd !== 16'hFF80) begin n_fail++; $display("FAIL ldb_data got=%h exp=ff80", got_wbd); end
        n_tests++; if (got_wbv !== 1) begin n_fail++; $display("FAIL ldb_wbv got=%0d exp=1", got_wbv); end
        n_tests++; if (got_unstable !== 0) begin n_fail++; $display("FAIL ldb_stable got=%0d exp=0", got_unstable); end
    endtask

    task automatic test_stb;
        logic [15:0] old = 16'hA5C3;
        mem[16'h1800] = old;
        run_op(STB, 16'h3000, 16'h1234, 16'h4321, 0);
        n_tests++; if (got_acc.size() !== 1) begin n_fail++; $display("FAIL stb_nacc got=%0d exp=1", got_acc.size()); end
        else begin
            n_tests++; if (got_acc[0] !== mk(1'b1, 16'h3000, 2'b01, 16'h3434)) begin n_fail++; $display("FAIL stb_req got=%h exp=%h", got_acc[0], mk(1'b1, 16'h3000, 2'b01, 16'h3434)); end
        end
        n_tests++; if (mem[16'h1800] !== 16'hA534) begin n_fail++; $display("FAIL stb_mem got=%h exp=a534", mem[16'h1800]); end
        n_tests++; if (got_wbd !== 16'h4321) begin n_fail++; $display("FAIL stb_data got=%h exp=4321", got_wbd); end
        n_tests++; if (got_stalls !== 0) begin n_fail++; $display("FAIL stb_stall got=%0d exp=0", got_stalls); end
    endtask

    task automatic test_ldi;
        mem[16'h2000] = 16'h5002; mem[16'h2801] = 16'hBEEF;
        run_op(LDI, 16'h4000, 16'h0, 16'h0, 0);
        n_tests++; if (got_acc.size() !== 2) begin n_fail++; $display("FAIL ldi_nacc got=%0d exp=2", got_acc.size()); end
        else begin
            n_tests++; if (got_acc[0] !== mk(1'b0, 16'h4000, 2'b11, 16'h0)) begin n_fail++; $display("FAIL ldi_req1 got=%h exp=%h", got_acc[0], mk(1'b0, 16'h4000, 2'b11, 16'h0)); end
            n_tests++; if (got_acc[1] !== mk(1'b0, 16'h5002, 2'b11, 16'h0)) begin n_fail++; $display("FAIL ldi_req2 got=%h exp=%h", got_acc[1], mk(1'b0, 16'h5002, 2'b11, 16'h0)); end
        end
        n_tests++; if (got_stalls !== 1) begin n_fail++; $display("FAIL ldi_stall got=%0d exp=1", got_stalls); end
        n_tests++; if (got_wbd !== 16'hBEEF) begin n_fail++; $display("FAIL ldi_data got=%h exp=beef", got_wbd); end
    endtask

    task automatic test_sti;
        mem[16'h2000] = 16'h6003; mem[16'h3001] = 16'h0000;
        run_op(STI, 16'h4000, 16'hCAFE, 16'h1111, 0);
        n_tests++; if (got_acc.size() !== 2) begin n_fail++; $display("FAIL sti_nacc got=%0d exp=2", got_acc.size()); end
        else begin
            n_tests++; if (got_acc[1] !== mk(1'b1, 16'h6002, 2'b11, 16'hCAFE)) begin n_fail++; $display("FAIL sti_req2 got=%h exp=%h", got_acc[1], mk(1'b1, 16'h6002, 2'b11, 16'hCAFE)); end
        end
        n_tests++; if (mem[16'h3001] !== 16'hCAFE) begin n_fail++; $display("FAIL sti_mem got=%h exp=cafe", mem[16'h3001]); end
        n_tests++; if (got_wbd !== 16'h1111) begin n_fail++; $display("FAIL sti_data got=%h exp=1111", got_wbd); end
    endtask

    task automatic test_reset_in_second;
        mem[16'h2000] = 16'h5002; mem[16'h2801] = 16'hBEEF;
        in_valid = 1; mem_op = LDI; addr_in = 16'h4000; dmem_resp = 0; #1;
        dmem_rdata = mem[16'h2000]; dmem_resp = 1; #1;
        n_tests++; if (mem_stall !== 1'b1) begin n_fail++; $display("FAIL rs_first_stall got=%b exp=1", mem_stall); end
        @(posedge clk); #1;
        dmem_resp = 0; #1;
        n_tests++; if (dmem_read !== 1'b1 || dmem_address !== 16'h5002) begin n_fail++; $display("FAIL rs_second_req got=%b/%h exp=1/5002", dmem_read, dmem_address); end
        reset = 1; #1;
        n_tests++; if ({dmem_read, dmem_write, mem_stall, wb_valid} !== 4'b0) begin n_fail++; $display("FAIL rs_during got=%b exp=0000", {dmem_read, dmem_write, mem_stall, wb_valid}); end
        @(posedge clk); #1;
        reset = 0; #1;
        n_tests++; if (dut.ptr !== 16'h0) begin n_fail++; $display("FAIL rs_ptr got=%h exp=0000", dut.ptr); end
        n_tests++; if (dmem_address !== 16'h4000 || wb_valid !== 1'b0) begin n_fail++; $display("FAIL rs_after got=%h/%b exp=4000/0", dmem_address, wb_valid); end
        run_op(LDI, 16'h4000, 16'h0, 16'h0, 1);
        n_tests++; if (got_stalls !== 3) begin n_fail++; $display("FAIL rs_redo_stall got=%0d exp=3", got_stalls); end
        n_tests++; if (got_wbd !== 16'hBEEF) begin n_fail++; $display("FAIL rs_redo_data got=%h exp=beef", got_wbd); end
    endtask

    task automatic test_idle;
        in_valid = 0; mem_op = LDR; dmem_resp = 1; dmem_rdata = 16'h1357; #1;
        n_tests++; if ({dmem_read, dmem_write, mem_stall, wb_valid} !== 4'b0) begin n_fail++; $display("FAIL idle_outs got=%b exp=0000", {dmem_read, dmem_write, mem_stall, wb_valid}); end
        @(posedge clk); #1;
        in_valid = 1; mem_op = NONE; alu_in = 16'h0777; #1;
        n_tests++; if (wb_valid !== 1'b1 || wb_data !== 16'h0777) begin n_fail++; $display("FAIL none_wb got=%b/%h exp=1/0777", wb_valid, wb_data); end
        n_tests++; if ({dmem_read, dmem_write, mem_stall} !== 3'b0) begin n_fail++; $display("FAIL none_outs got=%b exp=000", {dmem_read, dmem_write, mem_stall}); end
        @(posedge clk); #1;
        dmem_resp = 0;
        mem[16'h2000] = 16'h5002; mem[16'h2801] = 16'h2468;
        run_op(LDI, 16'h4001, 16'h0, 16'h0, 0);
        n_tests++; if (got_acc.size() !== 2 || got_stalls !== 1) begin n_fail++; $display("FAIL stray_resp got=%0d/%0d exp=2/1", got_acc.size(), got_stalls); end
        n_tests++; if (got_wbd !== 16'h2468) begin n_fail++; $display("FAIL stray_data got=%h exp=2468", got_wbd); end
    endtask

    // Back-to-back random ops against a per-instruction reference model.
    task automatic test_random;
        acc_t        exp_acc[$];
        logic [2:0]  op;
        logic [15:0] a, sr, alu, w, p, aw, exp_wbd;
        logic [1:0]  bsel;
        int          nwait, exp_stalls;
        for (int k = 0; k < 60; k++) begin
            op = 3'($urandom); a = 16'($urandom); sr = 16'($urandom); alu = 16'($urandom);
            nwait = $urandom_range(0, 3);
            aw = {a[15:1], 1'b0}; bsel = a[0] ? 2'b10 : 2'b01;
            w = mem[a[15:1]]; p = w;
            exp_acc.delete(); exp_wbd = alu; exp_stalls = nwait;
            case (op)
                LDR, TRAP: begin exp_acc.push_back(mk(1'b0, aw, 2'b11, 16'h0)); exp_wbd = w; end
                LDB: begin
                    exp_acc.push_back(mk(1'b0, a, bsel, 16'h0));
                    exp_wbd = a[0] ? {{8{w[15]}}, w[15:8]} : {{8{w[7]}}, w[7:0]};
                end
                STR: exp_acc.push_back(mk(1'b1, aw, 2'b11, sr));
                STB: exp_acc.push_back(mk(1'b1, a, bsel, {sr[7:0], sr[7:0]}));
                LDI: begin
                    exp_acc.push_back(mk(1'b0, aw, 2'b11, 16'h0));
                    exp_acc.push_back(mk(1'b0, {p[15:1], 1'b0}, 2'b11, 16'h0));
                    exp_wbd = mem[p[15:1]]; exp_stalls = 2 * nwait + 1;
                end
                STI: begin
                    exp_acc.push_back(mk(1'b0, aw, 2'b11, 16'h0));
                    exp_acc.push_back(mk(1'b1, {p[15:1], 1'b0}, 2'b11, sr));
                    exp_stalls = 2 * nwait + 1;
                end
                default: exp_stalls = 0;
            endcase
            run_op(op, a, sr, alu, nwait);
            n_tests++;
            if (got_timeout) begin
                n_fail++; $display("FAIL rnd%0d_timeout op=%0d no wb_valid", k, op);
                reset = 1; in_valid = 0; @(posedge clk); #1; reset = 0;
                continue;
            end
            if (got_wbd !== exp_wbd) begin n_fail++; $display("FAIL rnd%0d_data op=%0d got=%h exp=%h", k, op, got_wbd, exp_wbd); end
            n_tests++; if (got_stalls !== exp_stalls) begin n_fail++; $display("FAIL rnd%0d_stall op=%0d got=%0d exp=%0d", k, op, got_stalls, exp_stalls); end
            n_tests++; if (got_pc !== cur_pc || got_dest !== cur_dest) begin n_fail++; $display("FAIL rnd%0d_pass got=%h/%0d exp=%h/%0d", k, got_pc, got_dest, cur_pc, cur_dest); end
            n_tests++; if (got_unstable !== 0 || got_both !== 0) begin n_fail++; $display("FAIL rnd%0d_req_rules unstable=%0d both=%0d exp=0/0", k, got_unstable, got_both); end
            n_tests++; if (got_acc.size() !== exp_acc.size()) begin n_fail++; $display("FAIL rnd%0d_nacc op=%0d got=%0d exp=%0d", k, op, got_acc.size(), exp_acc.size()); end
            else begin
                for (int j = 0; j < exp_acc.size(); j++) begin
                    n_tests++; if (got_acc[j] !== exp_acc[j]) begin n_fail++; $display("FAIL rnd%0d_acc%0d op=%0d got=%h exp=%h", k, j, op, got_acc[j], exp_acc[j]); end
                end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);
        reset = 1; in_valid = 0; mem_op = NONE; addr_in = 0; sr_in = 0;
        alu_in = 0; pc_in = 0; dest_in = 0; dmem_rdata = 0; dmem_resp = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_ldb();
        test_stb();
        test_ldi();
        test_sti();
        test_reset_in_second();
        test_idle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
